// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared defaults and width helper for sync_fifo
// Contents: DEFAULT_DATA_WIDTH, DEFAULT_DEPTH, cnt_width(depth)
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 8;

    // The count must represent 0..DEPTH inclusive, hence DEPTH+1 states.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - dual-port register array, synchronous write, registered read
// Ports: clk, reset (sync, active-high, clears rd_data only),
//        wr_en/wr_addr/wr_data write port, rd_en/rd_addr/rd_data registered read port
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is never cleared; only the read register returns to zero.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered read data and count/flags
// Ports: clk, reset (sync, active-high), data/wr write side, rd read side,
//        data_out registered read data, empty, full, count (0..DEPTH)
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int CNT_WIDTH  = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wr,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_WIDTH-1:0]  count
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

    logic [PTR_WIDTH-1:0] wptr;
    logic [PTR_WIDTH-1:0] rptr;
    logic                 wr_ok;
    logic                 rd_ok;

    // Acceptance uses pre-edge flags; reset masks both so it wins the edge
    // and a write issued during reset cannot land in the array.
    assign wr_ok = wr && !full  && !reset;
    assign rd_ok = rd && !empty && !reset;

    // Flags decode from the count register only, so they move on edges only.
    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok),
        .wr_addr (wptr),
        .wr_data (data),
        .rd_en   (rd_ok),
        .rd_addr (rptr),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed self-checking bench for sync_fifo
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       wr;
    logic       rd;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic [3:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    sync_fifo dut (
        .clk      (clk),
        .reset    (reset),
        .data     (data),
        .wr       (wr),
        .rd       (rd),
        .data_out (data_out),
        .empty    (empty),
        .full     (full),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, take one edge, settle 1 time unit past it.
    task automatic step(input logic r, input logic w, input logic rdq, input logic [7:0] d);
        reset = r;
        wr    = w;
        rd    = rdq;
        data  = d;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
    endtask

    task automatic check_state(input string tag, input int c, input logic e, input logic f);
        check({tag, "_count"}, 32'(count), 32'(c));
        check({tag, "_empty"}, 32'(empty), 32'(e));
        check({tag, "_full"},  32'(full),  32'(f));
    endtask

    initial begin
        reset = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        data  = 8'h00;
        @(posedge clk);
        #1;

        // Reset wins over rd and wr on the same edge.
        step(1'b1, 1'b1, 1'b1, 8'h55);
        check_state("reset", 0, 1'b1, 1'b0);
        check("reset_dout", 32'(data_out), 32'h00);

        // Single round trips.
        step(1'b0, 1'b1, 1'b0, 8'hAA);
        check_state("rt1_wr", 1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check("rt1_dout", 32'(data_out), 32'hAA);
        check_state("rt1_rd", 0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'hCC);
        check_state("rt2_wr", 1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check("rt2_dout", 32'(data_out), 32'hCC);
        check_state("rt2_rd", 0, 1'b1, 1'b0);

        // Fill, overflow, drain.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'(i + 1));
            check("fill_count", 32'(count), 32'(i + 1));
        end
        check_state("filled", 8, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        check_state("overflow", 8, 1'b0, 1'b1);
        check("overflow_dout", 32'(data_out), 32'hCC);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check("drain_dout", 32'(data_out), 32'(i + 1));
            check("drain_count", 32'(count), 32'(7 - i));
        end
        check_state("drained", 0, 1'b1, 1'b0);

        // Underflow leaves everything alone.
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check("underflow_dout", 32'(data_out), 32'h08);
        check_state("underflow", 0, 1'b1, 1'b0);

        // Write 5, read 5, write 6 so both pointers wrap.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
        check("w5_count", 32'(count), 32'd5);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check("r5_dout", 32'(data_out), 32'(8'h10 + i));
        end
        check_state("r5_done", 0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
        check("w6_count", 32'(count), 32'd6);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check("r3_dout", 32'(data_out), 32'(8'h20 + i));
        end
        check("r3_count", 32'(count), 32'd3);

        // Simultaneous rd/wr at count 3 for 4 cycles.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1, 8'(8'h30 + i));
            check("simul_dout", 32'(data_out), (i < 3) ? 32'(8'h23 + i) : 32'h30);
            check("simul_count", 32'(count), 32'd3);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check("simul_tail", 32'(data_out), 32'(8'h31 + i));
        end
        check_state("simul_done", 0, 1'b1, 1'b0);

        // Simultaneous on empty: write only, no bypass.
        step(1'b0, 1'b1, 1'b1, 8'h40);
        check_state("empty_rw", 1, 1'b0, 1'b0);
        check("empty_rw_dout", 32'(data_out), 32'h33);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check("empty_rw_read", 32'(data_out), 32'h40);

        // Simultaneous on full: read only, write data lost.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h50 + i));
        check_state("full2", 8, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 8'h99);
        check_state("full_rw", 7, 1'b0, 1'b0);
        check("full_rw_dout", 32'(data_out), 32'h50);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check("full_rw_drain", 32'(data_out), 32'(8'h51 + i));
        end
        check_state("full_rw_done", 0, 1'b1, 1'b0);

        // Mid-operation reset.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
        check("mid_count", 32'(count), 32'd5);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check_state("mid_reset", 0, 1'b1, 1'b0);
        check("mid_reset_dout", 32'(data_out), 32'h00);
        step(1'b0, 1'b1, 1'b0, 8'h77);
        check_state("post_wr", 1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check("post_rd_dout", 32'(data_out), 32'h77);
        check_state("post_rd", 0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
